// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : FWFT byte queue fed by UART receiver frames, with framing
//               error counting and sticky overflow flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               rx_frame,
    input  logic                     rx_done,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               frame_err_count,
    input  logic                     clear_errors
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [7:0]       r_mem_q [DEPTH];
    logic [PTR_W-1:0] r_head_q, w_head_d;
    logic [PTR_W-1:0] r_tail_q, w_tail_d;
    logic [PTR_W:0]   r_count_q, w_count_d;
    logic             r_overflow_q, w_overflow_d;
    logic [7:0]       r_err_q, w_err_d;

    logic w_good;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_bad;

    assign w_good = ~rx_frame[0] & rx_frame[9];
    assign w_full = (r_count_q == CNT_FULL);
    assign w_pop  = (r_count_q != '0) & rd_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_push = rx_done & w_good & (~w_full | w_pop);
    assign w_drop = rx_done & w_good & w_full & ~w_pop;
    assign w_bad  = rx_done & ~w_good;

    always_comb begin
        w_head_d     = r_head_q;
        w_tail_d     = r_tail_q;
        w_count_d    = r_count_q;
        w_overflow_d = r_overflow_q;
        w_err_d      = r_err_q;

        if (w_pop) begin
            w_head_d = r_head_q + PTR_ONE;
        end
        if (w_push) begin
            w_tail_d = r_tail_q + PTR_ONE;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + CNT_ONE;
            2'b01:   w_count_d = r_count_q - CNT_ONE;
            default: w_count_d = r_count_q;
        endcase

        // Events in the same cycle as clear_errors win over the clear.
        if (w_drop) begin
            w_overflow_d = 1'b1;
        end else if (clear_errors) begin
            w_overflow_d = 1'b0;
        end

        if (w_bad) begin
            if (clear_errors) begin
                w_err_d = 8'd1;
            end else if (r_err_q != 8'hFF) begin
                w_err_d = r_err_q + 8'd1;
            end
        end else if (clear_errors) begin
            w_err_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_q     <= '0;
            r_tail_q     <= '0;
            r_count_q    <= '0;
            r_overflow_q <= 1'b0;
            r_err_q      <= 8'd0;
        end else begin
            r_head_q     <= w_head_d;
            r_tail_q     <= w_tail_d;
            r_count_q    <= w_count_d;
            r_overflow_q <= w_overflow_d;
            r_err_q      <= w_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_q[r_tail_q] <= rx_frame[8:1];
        end
    end

    assign rd_valid        = (r_count_q != '0);
    assign rd_data         = rd_valid ? r_mem_q[r_head_q] : 8'h00;
    assign count           = r_count_q;
    assign overflow        = r_overflow_q;
    assign frame_err_count = r_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Scoreboard-driven self-checking bench for uart_rx_fifo.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic [9:0] rx_frame;
    logic       rx_done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] frame_err_count;
    logic       clear_errors;

    int errors;
    int checks;

    logic [7:0] m_q [$];
    logic       m_ovf;
    logic [7:0] m_err;

    uart_rx_fifo #(.DEPTH(DEPTH)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .rx_frame        (rx_frame),
        .rx_done         (rx_done),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .count           (count),
        .overflow        (overflow),
        .frame_err_count (frame_err_count),
        .clear_errors    (clear_errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [9:0] good_frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // One clock cycle of stimulus; updates the scoreboard and reports the
    // byte the DUT presented and the byte the scoreboard expected on a pop.
    task automatic cyc(input logic [9:0] f, input logic done, input logic rdy,
                       input logic clr, output logic popped,
                       output logic [7:0] exp_b, output logic [7:0] act_b);
        logic good;
        logic full;
        rx_frame     = f;
        rx_done      = done;
        rd_ready     = rdy;
        clear_errors = clr;
        #1;
        act_b  = rd_data;
        popped = rdy && (m_q.size() != 0);
        exp_b  = popped ? m_q[0] : 8'h00;
        good   = !f[0] && f[9];
        full   = (m_q.size() == DEPTH);
        if (popped) void'(m_q.pop_front());
        if (done && good && (!full || popped)) m_q.push_back(f[8:1]);
        if (done && good && full && !popped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (done && !good) m_err = clr ? 8'd1 : ((m_err == 8'hFF) ? 8'hFF : m_err + 8'd1);
        else if (clr) m_err = 8'd0;
        @(posedge clk);
        #1;
        rx_done      = 1'b0;
        rd_ready     = 1'b0;
        clear_errors = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_done = 1'b0; rd_ready = 1'b0; clear_errors = 1'b0; rx_frame = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_q.delete(); m_ovf = 1'b0; m_err = 8'd0;
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_queue: count=%0d valid=%b data=%h want 0/0/00", count, rd_valid, rd_data);
        end
        checks++;
        if (overflow !== 1'b0 || frame_err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_errs: ovf=%b err=%0d want 0/0", overflow, frame_err_count);
        end
    endtask

    task automatic test_single();
        logic p; logic [7:0] e, a;
        cyc(10'b1_01010101_0, 1'b1, 1'b0, 1'b0, p, e, a);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h55 || count !== 5'd1) begin
            errors++;
            $display("FAIL single_push: valid=%b data=%h count=%0d want 1/55/1", rd_valid, rd_data, count);
        end
        cyc(10'h000, 1'b0, 1'b1, 1'b0, p, e, a);
        checks++;
        if (a !== 8'h55) begin
            errors++;
            $display("FAIL single_pop_data: got %h want 55", a);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || count !== 5'd0) begin
            errors++;
            $display("FAIL single_empty: valid=%b data=%h count=%0d want 0/00/0", rd_valid, rd_data, count);
        end
    endtask

    task automatic test_fill_overflow();
        logic p; logic [7:0] e, a;
        for (int i = 0; i < DEPTH; i++) cyc(good_frame(8'(i)), 1'b1, 1'b0, 1'b0, p, e, a);
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_count: count=%0d ovf=%b want 16/0", count, overflow);
        end
        cyc(good_frame(8'hAA), 1'b1, 1'b0, 1'b0, p, e, a);
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow: count=%0d ovf=%b want 16/1", count, overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cyc(10'h000, 1'b0, 1'b1, 1'b0, p, e, a);
            checks++;
            if (!p || a !== 8'(i) || a !== e) begin
                errors++;
                $display("FAIL fill_order[%0d]: got %h want %h", i, a, 8'(i));
            end
        end
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_drained: valid=%b count=%0d ovf=%b want 0/0/1", rd_valid, count, overflow);
        end
        cyc(10'h000, 1'b0, 1'b0, 1'b1, p, e, a);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic p; logic [7:0] e, a;
        for (int i = 0; i < DEPTH; i++) cyc(good_frame(8'(8'h10 + i)), 1'b1, 1'b0, 1'b0, p, e, a);
        cyc(good_frame(8'h77), 1'b1, 1'b1, 1'b0, p, e, a);
        checks++;
        if (a !== 8'h10 || count !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop: data=%h count=%0d ovf=%b want 10/16/0", a, count, overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cyc(10'h000, 1'b0, 1'b1, 1'b0, p, e, a);
            checks++;
            if (a !== ((i == DEPTH - 1) ? 8'h77 : 8'(8'h11 + i)) || a !== e) begin
                errors++;
                $display("FAIL full_drain[%0d]: got %h want %h", i, a, e);
            end
        end
    endtask

    task automatic test_framing();
        logic p; logic [7:0] e, a;
        cyc(10'b0_10101010_0, 1'b1, 1'b0, 1'b0, p, e, a);
        cyc(10'b1_11001100_1, 1'b1, 1'b0, 1'b0, p, e, a);
        checks++;
        if (frame_err_count !== 8'd2 || count !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL frame_bad2: err=%0d count=%0d valid=%b ovf=%b want 2/0/0/0",
                     frame_err_count, count, rd_valid, overflow);
        end
        for (int i = 0; i < 300; i++) cyc(10'h3FF, 1'b1, 1'b0, 1'b0, p, e, a);
        checks++;
        if (frame_err_count !== 8'hFF || frame_err_count !== m_err) begin
            errors++;
            $display("FAIL frame_saturate: got %h want FF", frame_err_count);
        end
        cyc(10'h000, 1'b0, 1'b1, 1'b0, p, e, a);
        checks++;
        if (frame_err_count !== 8'hFF || count !== 5'd0) begin
            errors++;
            $display("FAIL frame_idle: err=%h count=%0d want FF/0", frame_err_count, count);
        end
        cyc(10'h000, 1'b1, 1'b0, 1'b1, p, e, a);
        checks++;
        if (frame_err_count !== 8'd1) begin
            errors++;
            $display("FAIL frame_clear_prio: got %0d want 1", frame_err_count);
        end
        cyc(10'h000, 1'b0, 1'b0, 1'b1, p, e, a);
        checks++;
        if (frame_err_count !== 8'd0) begin
            errors++;
            $display("FAIL frame_clear: got %0d want 0", frame_err_count);
        end
    endtask

    task automatic test_wrap();
        logic p; logic [7:0] e, a;
        int sent;
        int got;
        logic do_push;
        sent = 0;
        got  = 0;
        for (int cy = 0; cy < 600 && got < 40; cy++) begin
            do_push = (sent < 40) && (m_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            cyc(good_frame(8'(8'h80 + sent)), do_push, 1'($urandom_range(0, 1)), 1'b0, p, e, a);
            if (do_push) sent++;
            if (p) begin
                checks++;
                if (a !== e || a !== 8'(8'h80 + got)) begin
                    errors++;
                    $display("FAIL wrap_order[%0d]: got %h want %h", got, a, 8'(8'h80 + got));
                end
                got++;
            end
            checks++;
            if (count !== 5'(m_q.size())) begin
                errors++;
                $display("FAIL wrap_count: got %0d want %0d", count, m_q.size());
            end
        end
        checks++;
        if (got != 40) begin
            errors++;
            $display("FAIL wrap_budget: delivered %0d want 40", got);
        end
    endtask

    task automatic test_reset_mid();
        logic p; logic [7:0] e, a;
        for (int i = 0; i < 5; i++) cyc(good_frame(8'(8'hC0 + i)), 1'b1, 1'b0, 1'b0, p, e, a);
        cyc(10'h3FF, 1'b1, 1'b0, 1'b0, p, e, a);
        checks++;
        if (count !== 5'd5 || frame_err_count !== 8'd1) begin
            errors++;
            $display("FAIL pre_reset: count=%0d err=%0d want 5/1", count, frame_err_count);
        end
        rst = 1'b1; rx_done = 1'b1; rd_ready = 1'b1; clear_errors = 1'b0;
        rx_frame = good_frame(8'hEE);
        @(posedge clk);
        #1;
        rst = 1'b0; rx_done = 1'b0; rd_ready = 1'b0;
        m_q.delete(); m_ovf = 1'b0; m_err = 8'd0;
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || overflow !== 1'b0 ||
            frame_err_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: count=%0d valid=%b data=%h ovf=%b err=%0d want 0/0/00/0/0",
                     count, rd_valid, rd_data, overflow, frame_err_count);
        end
        cyc(good_frame(8'h3C), 1'b1, 1'b0, 1'b0, p, e, a);
        checks++;
        if (count !== 5'd1 || rd_data !== 8'h3C) begin
            errors++;
            $display("FAIL post_reset: count=%0d data=%h want 1/3C", count, rd_data);
        end
    endtask

    task automatic test_push_empty_ready();
        logic p; logic [7:0] e, a;
        cyc(10'h000, 1'b0, 1'b1, 1'b0, p, e, a);
        cyc(good_frame(8'h9A), 1'b1, 1'b1, 1'b0, p, e, a);
        checks++;
        if (count !== 5'd1 || rd_valid !== 1'b1 || rd_data !== 8'h9A) begin
            errors++;
            $display("FAIL push_empty_ready: count=%0d valid=%b data=%h want 1/1/9A", count, rd_valid, rd_data);
        end
        cyc(10'h000, 1'b0, 1'b1, 1'b0, p, e, a);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_framing();
        test_push_empty_ready();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameters SHALL be as follows:
- DEPTH, default 16. Number of byte entries. Power of two, 2 or more.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1. Single clock; all logic on the posedge.
- rst, in, 1. Reset; synchronous, active-high.
- rx_frame, in, 10. Received frame from the UART receiver: bit0 start, bits[8:1] data LSB-first, bit9 stop.
- rx_done, in, 1. One-cycle strobe; rx_frame is complete and stable this cycle.
- rd_data, out, 8. Head-of-queue byte.
- rd_valid, out, 1. Queue non-empty.
- rd_ready, in, 1. Consumer accepts rd_data this cycle.
- count, out, $clog2(DEPTH)+1. Current occupancy, 0..DEPTH.
- overflow, out, 1. Sticky: a good frame was dropped because the queue was full.
- frame_err_count, out, 8. Saturating count of malformed frames.
- clear_errors, in, 1. Clears overflow and frame_err_count.

Function
REQ-003 A frame SHALL be good iff rx_frame[0]==0 and rx_frame[9]==1; otherwise it SHALL be bad.
REQ-004 On rx_done with a good frame and the queue not full, rx_frame[8:1] SHALL be written at the tail, the tail pointer SHALL advance, and count SHALL increment.
REQ-005 The queue SHALL be first-word-fall-through.
- rd_valid = (count != 0).
- rd_data = head entry when rd_valid=1, else 8'h00.
REQ-006 A pop SHALL occur iff rd_valid && rd_ready in the same cycle. The head pointer SHALL advance and count SHALL decrement.
REQ-007 Latency: a byte pushed on the cycle-N rx_done SHALL appear on rd_data with rd_valid=1 at cycle N+1 when the queue was empty.
REQ-008 Pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH.
REQ-009 Push and pop in the same cycle:
- Both SHALL take effect.
- count SHALL be unchanged.
- This applies when full: the pop frees the slot, so the push is accepted and overflow is not set.
REQ-010 Push while empty with rd_ready=1: the push SHALL occur, no pop SHALL occur, and count SHALL become 1.
REQ-011 Good frame while full with no simultaneous pop: the byte SHALL be dropped, the queue SHALL be unchanged, and overflow SHALL be set to 1.
REQ-012 Bad frame:
- SHALL NOT be pushed.
- SHALL increment frame_err_count, saturating at 8'hFF.
- SHALL NOT affect overflow.
REQ-013 clear_errors=1 SHALL zero overflow and frame_err_count on the next edge.
- An overflow or bad-frame event in the same cycle SHALL take priority: overflow=1, or frame_err_count=1.
REQ-014 rx_done=0 SHALL leave rx_frame ignored. rd_ready with rd_valid=0 SHALL have no effect.
REQ-015 count SHALL never exceed DEPTH and never underflow below 0.
REQ-016 Storage SHALL be a register/RAM array. Writes SHALL be registered on clk.

Reset
REQ-017 While rst=1 at a posedge, the following SHALL apply:
- Head pointer, tail pointer and count SHALL be 0.
- rd_valid=0, rd_data=8'h00, overflow=0, frame_err_count=0.
- Storage contents SHALL NOT be reset.
REQ-018 rst SHALL take priority over rx_done, rd_ready and clear_errors.
- A reset mid-operation SHALL discard all queued bytes.
- rx_done asserted during reset SHALL be ignored.
REQ-019 Outputs SHALL be valid from the first cycle after rst deasserts.

Verification
REQ-020 Single byte: rx_frame=10'b1_01010101_0 with rx_done -> next cycle rd_valid=1, rd_data=8'h55, count=1. Then rd_ready=1 for one cycle -> rd_valid=0, rd_data=8'h00, count=0.
REQ-021 Fill and order: push bytes 0x00..0x0F with rd_ready=0 -> count=16. A 17th good frame (0xAA) -> overflow=1, count=16. Then drain -> rd_data sequence 0x00..0x0F, 0xAA absent.
REQ-022 Full with simultaneous push and pop: full queue, rx_done (data 0x77) and rd_ready=1 in the same cycle -> count stays 16, overflow=0, and 0x77 is the 16th byte drained after the pop.
REQ-023 Framing errors:
- Frames with stop=0 and with start=1 -> not pushed, frame_err_count=2.
- 300 bad frames -> frame_err_count=8'hFF.
- clear_errors together with a bad frame -> frame_err_count=1.
REQ-024 Wrap and reset:
- Push/pop 40 bytes with random rd_ready -> all bytes delivered in order across pointer wrap.
- Assert rst with count=5 -> next cycle count=0, rd_valid=0, overflow=0.
